// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants, state type and parity helper
// Optional macro UART_PARITY_EN adds the PARITY state and an even-parity bit.
package uart_pkg;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_PARITY_EN
      PARITY = 3'd4,
`endif
      STOP   = 3'd3
   } uart_state_t;

   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - reloadable bit-period down-counter with half-period option
// tick is high while the count sits at zero; the owner reloads on every tick it consumes.
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic half,
   output logic tick
);

   localparam logic [15:0] FULL_LEN = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LEN = 16'(CLKS_PER_BIT / 2 - 1);

   logic [15:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 16'd0;
      end else if (load) begin
         cnt <= half ? HALF_LEN : FULL_LEN;
      end else if (cnt != 16'd0) begin
         cnt <= cnt - 16'd1;
      end
   end

   assign tick = (cnt == 16'd0);

endmodule

// File: rtl/uart_txrx.sv
// rtl/uart_txrx.sv - independent 8N1 UART transmitter and receiver
// Optional macro UART_PARITY_EN: even parity after D7 and an rx_parity_err output.
module uart_txrx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_tx_en,
   input  logic [7:0] uart_tx_data,
   output logic       tx_busy,
   output logic       uart_txd,
   input  logic       uart_rxd,
   output logic       rx_busy,
   output logic [7:0] uart_rx_data,
   output logic       rx_valid
`ifdef UART_PARITY_EN
   ,
   output logic       rx_parity_err
`endif
);

   uart_state_t tx_state;
   logic [7:0]  tx_shreg;
   logic [2:0]  tx_bit_cnt;
   logic        tx_tick;
   logic        tx_load;
`ifdef UART_PARITY_EN
   logic        tx_par;
`endif

   assign tx_load = (tx_state == IDLE) ? uart_tx_en : tx_tick;

   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
      .clk  (clk),
      .rst  (rst),
      .load (tx_load),
      .half (1'b0),
      .tick (tx_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state   <= IDLE;
         tx_shreg   <= 8'h00;
         tx_bit_cnt <= 3'd0;
         uart_txd   <= 1'b1;
         tx_busy    <= 1'b0;
`ifdef UART_PARITY_EN
         tx_par     <= 1'b0;
`endif
      end else begin
         case (tx_state)
            IDLE: begin
               if (uart_tx_en) begin
                  tx_shreg <= uart_tx_data;
`ifdef UART_PARITY_EN
                  tx_par   <= even_parity(uart_tx_data);
`endif
                  tx_state <= START;
                  uart_txd <= 1'b0;
                  tx_busy  <= 1'b1;
               end
            end
            START: begin
               if (tx_tick) begin
                  tx_state   <= DATA;
                  tx_bit_cnt <= 3'd0;
                  uart_txd   <= tx_shreg[0];
                  tx_shreg   <= {1'b0, tx_shreg[7:1]};
               end
            end
            DATA: begin
               if (tx_tick) begin
                  if (tx_bit_cnt == 3'(DATA_BITS - 1)) begin
                     tx_bit_cnt <= 3'd0;
`ifdef UART_PARITY_EN
                     tx_state   <= PARITY;
                     uart_txd   <= tx_par;
`else
                     tx_state   <= STOP;
                     uart_txd   <= 1'b1;
`endif
                  end else begin
                     tx_bit_cnt <= tx_bit_cnt + 3'd1;
                     uart_txd   <= tx_shreg[0];
                     tx_shreg   <= {1'b0, tx_shreg[7:1]};
                  end
               end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
               if (tx_tick) begin
                  tx_state <= STOP;
                  uart_txd <= 1'b1;
               end
            end
`endif
            STOP: begin
               if (tx_tick) begin
                  if (tx_bit_cnt == 3'(STOP_BITS - 1)) begin
                     tx_state <= IDLE;
                     tx_busy  <= 1'b0;
                  end else begin
                     tx_bit_cnt <= tx_bit_cnt + 3'd1;
                  end
               end
            end
            default: begin
               tx_state <= IDLE;
               uart_txd <= 1'b1;
               tx_busy  <= 1'b0;
            end
         endcase
      end
   end

   uart_state_t rx_state;
   logic        rx_s1, rx_s2, rx_prev;
   logic [1:0]  rx_warm;
   logic [7:0]  rx_shreg;
   logic [2:0]  rx_bit_cnt;
   logic        rx_tick;
   logic        rx_load;
   logic        rx_start;
`ifdef UART_PARITY_EN
   logic        rx_perr;
`endif

   // rx_prev only carries line samples once the reset value of the
   // synchronizer has flushed, so a line held low through reset is no edge.
   assign rx_start = (rx_state == IDLE) && rx_prev && !rx_s2;
   assign rx_load  = (rx_state == IDLE) ? rx_start : rx_tick;

   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
      .clk  (clk),
      .rst  (rst),
      .load (rx_load),
      .half (rx_state == IDLE),
      .tick (rx_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1        <= 1'b1;
         rx_s2        <= 1'b1;
         rx_prev      <= 1'b0;
         rx_warm      <= 2'd0;
         rx_state     <= IDLE;
         rx_shreg     <= 8'h00;
         rx_bit_cnt   <= 3'd0;
         rx_busy      <= 1'b0;
         rx_valid     <= 1'b0;
         uart_rx_data <= 8'h00;
`ifdef UART_PARITY_EN
         rx_perr       <= 1'b0;
         rx_parity_err <= 1'b0;
`endif
      end else begin
         rx_s1    <= uart_rxd;
         rx_s2    <= rx_s1;
         rx_prev  <= (rx_warm == 2'd2) ? rx_s2 : 1'b0;
         rx_valid <= 1'b0;
         if (rx_warm != 2'd2) begin
            rx_warm <= rx_warm + 2'd1;
         end
         case (rx_state)
            IDLE: begin
               if (rx_start) begin
                  rx_state <= START;
                  rx_busy  <= 1'b1;
               end
            end
            START: begin
               if (rx_tick) begin
                  if (rx_s2) begin
                     rx_state <= IDLE;
                     rx_busy  <= 1'b0;
                  end else begin
                     rx_state   <= DATA;
                     rx_bit_cnt <= 3'd0;
                  end
               end
            end
            DATA: begin
               if (rx_tick) begin
                  rx_shreg <= {rx_s2, rx_shreg[7:1]};
                  if (rx_bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                     rx_state <= PARITY;
`else
                     rx_state <= STOP;
`endif
                  end else begin
                     rx_bit_cnt <= rx_bit_cnt + 3'd1;
                  end
               end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
               if (rx_tick) begin
                  rx_perr  <= rx_s2 ^ even_parity(rx_shreg);
                  rx_state <= STOP;
               end
            end
`endif
            STOP: begin
               if (rx_tick) begin
                  if (rx_s2) begin
                     uart_rx_data <= rx_shreg;
                     rx_valid     <= 1'b1;
`ifdef UART_PARITY_EN
                     rx_parity_err <= rx_perr;
`endif
                  end
                  rx_state <= IDLE;
                  rx_busy  <= 1'b0;
               end
            end
            default: begin
               rx_state <= IDLE;
               rx_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_txrx.sv
// tb/tb_uart_txrx.sv - self-checking bench for uart_txrx with a frame-level reference model
// Optional macro UART_PARITY_EN enables the parity frame length and parity scenarios.
module tb_uart_txrx;

   localparam int C = 16;
`ifdef UART_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_en = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_busy, txd, rx_busy, rx_valid;
   logic [7:0] rx_data;
   logic       rxd;
   logic       rxd_drv = 1'b1;
   logic       loop_en = 1'b0;
`ifdef UART_PARITY_EN
   logic       rx_parity_err;
   logic       perr_got[$];
`endif
   logic [7:0] rx_got[$];
   int         checks = 0;
   int         errors = 0;

   assign rxd = loop_en ? txd : rxd_drv;

   uart_txrx #(.CLKS_PER_BIT(C)) dut (
      .clk          (clk),
      .rst          (rst),
      .uart_tx_en   (tx_en),
      .uart_tx_data (tx_data),
      .tx_busy      (tx_busy),
      .uart_txd     (txd),
      .uart_rxd     (rxd),
      .rx_busy      (rx_busy),
      .uart_rx_data (rx_data),
      .rx_valid     (rx_valid)
`ifdef UART_PARITY_EN
      ,
      .rx_parity_err(rx_parity_err)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid) begin
         rx_got.push_back(rx_data);
`ifdef UART_PARITY_EN
         perr_got.push_back(rx_parity_err);
`endif
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish within 1 ms");
      $fatal(1);
   end

   // Line level of each bit position of a frame carrying d, in transmit order.
   function automatic logic [NB-1:0] frame_bits(input logic [7:0] d);
      logic [NB-1:0] fb;
      int ones;
      ones  = 0;
      fb    = '0;
      fb[0] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         fb[k+1] = ((d >> k) & 8'd1) != 8'd0;
         ones    = ones + int'(fb[k+1]);
      end
`ifdef UART_PARITY_EN
      fb[9] = (ones % 2) == 1;
`endif
      fb[NB-1] = 1'b1;
      return fb;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) step();
      rst = 1'b0;
   endtask

   // Requests a frame in the current cycle and checks it to the first idle cycle.
   task automatic tx_frame(input logic [7:0] d, input bit noise);
      logic [NB-1:0] expv, obs;
      int bad, busy_cnt;
      expv     = frame_bits(d);
      obs      = '0;
      bad      = 0;
      busy_cnt = 0;
      tx_en    = 1'b1;
      tx_data  = d;
      step();
      tx_en    = 1'b0;
      for (int i = 0; i < NB * C; i++) begin
         if (i % C == C / 2) obs[i / C] = txd;
         if (txd !== expv[i / C]) bad++;
         if (tx_busy === 1'b1) busy_cnt++;
         if (noise) begin
            tx_en   = 1'($urandom_range(0, 1));
            tx_data = 8'($urandom);
         end
         step();
      end
      tx_en = 1'b0;
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL tx_line data=%h: got bits %b want %b (%0d bad cycles)", d, obs, expv, bad);
      end
      checks++;
      if (busy_cnt !== NB * C) begin
         errors++;
         $display("FAIL tx_busy_len data=%h: got %0d want %0d", d, busy_cnt, NB * C);
      end
      checks++;
      if (tx_busy !== 1'b0 || txd !== 1'b1) begin
         errors++;
         $display("FAIL tx_end_idle data=%h: got busy=%b txd=%b want busy=0 txd=1", d, tx_busy, txd);
      end
   endtask

   task automatic rx_drive(input logic [7:0] d, input logic stop, input bit flip_par);
      logic [NB-1:0] fb;
      fb = frame_bits(d);
      fb[NB-1] = stop;
`ifdef UART_PARITY_EN
      if (flip_par) fb[9] = ~fb[9];
`else
      if (flip_par) fb[0] = 1'b0;
`endif
      for (int k = 0; k < NB; k++) begin
         rxd_drv = fb[k];
         repeat (C) step();
      end
      rxd_drv = 1'b1;
      repeat (C) step();
   endtask

   task automatic test_reset();
      do_reset(2);
      checks++;
      if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", txd); end
      checks++;
      if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
      checks++;
      if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_rx_busy: got %b want 0", rx_busy); end
      checks++;
      if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
      checks++;
      if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
   endtask

   task automatic test_tx_pattern();
      logic [7:0] sent[$];
      loop_en = 1'b1;
      repeat (4) step();
      rx_got.delete();
      tx_frame(8'h11, 1'b0);
      sent.push_back(8'h11);
      for (int n = 0; n < 3; n++) begin
         logic [7:0] d;
         d = 8'($urandom);
         repeat (1 + $urandom_range(0, 5)) step();
         tx_frame(d, 1'b1);
         sent.push_back(d);
      end
      repeat (20) step();
      checks++;
      if (rx_got.size() !== sent.size()) begin
         errors++;
         $display("FAIL loop_count: got %0d bytes want %0d", rx_got.size(), sent.size());
      end else begin
         for (int n = 0; n < sent.size(); n++) begin
            checks++;
            if (rx_got[n] !== sent[n]) begin
               errors++;
               $display("FAIL loop_byte%0d: got %h want %h", n, rx_got[n], sent[n]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      loop_en = 1'b1;
      rx_got.delete();
      tx_frame(8'hA5, 1'b0);
      tx_frame(8'h3C, 1'b0);
      repeat (20) step();
      checks++;
      if (rx_got.size() !== 2) begin
         errors++;
         $display("FAIL b2b_count: got %0d pulses want 2", rx_got.size());
      end else begin
         checks++;
         if (rx_got[0] !== 8'hA5 || rx_got[1] !== 8'h3C) begin
            errors++;
            $display("FAIL b2b_bytes: got %h %h want a5 3c", rx_got[0], rx_got[1]);
         end
      end
   endtask

   task automatic test_rx_frames();
      logic [7:0] last, d;
      loop_en = 1'b0;
      rxd_drv = 1'b1;
      repeat (4) step();
      last = 8'h00;
      for (int n = 0; n < 4; n++) begin
         d = 8'($urandom);
         rx_got.delete();
         rx_drive(d, 1'b1, 1'b0);
         checks++;
         if (rx_got.size() !== 1 || rx_data !== d) begin
            errors++;
            $display("FAIL rx_byte%0d: got %0d pulses data=%h want 1 pulse data=%h", n, rx_got.size(), rx_data, d);
         end
         last = d;
      end
      rx_got.delete();
      rx_drive(~last, 1'b0, 1'b0);
      checks++;
      if (rx_got.size() !== 0 || rx_data !== last || rx_busy !== 1'b0) begin
         errors++;
         $display("FAIL rx_bad_stop: got %0d pulses data=%h busy=%b want 0 pulses data=%h busy=0",
                  rx_got.size(), rx_data, rx_busy, last);
      end
      d = 8'($urandom);
      rx_got.delete();
      rx_drive(d, 1'b1, 1'b0);
      checks++;
      if (rx_got.size() !== 1 || rx_data !== d) begin
         errors++;
         $display("FAIL rx_recover: got %0d pulses data=%h want 1 pulse data=%h", rx_got.size(), rx_data, d);
      end
   endtask

   task automatic test_glitch();
      bit seen_busy;
      loop_en = 1'b0;
      rxd_drv = 1'b1;
      repeat (4) step();
      rx_got.delete();
      rxd_drv = 1'b0;
      repeat (3) step();
      seen_busy = (rx_busy === 1'b1);
      rxd_drv = 1'b1;
      repeat (8) step();
      checks++;
      if (!seen_busy || rx_busy !== 1'b0) begin
         errors++;
         $display("FAIL glitch_busy: got busy_seen=%0d busy_at_11=%b want 1 and 0", seen_busy, rx_busy);
      end
      repeat (2 * C) step();
      checks++;
      if (rx_got.size() !== 0) begin
         errors++;
         $display("FAIL glitch_valid: got %0d pulses want 0", rx_got.size());
      end
   endtask

   task automatic test_reset_mid_tx();
      logic [7:0] d;
      loop_en = 1'b1;
      rx_got.delete();
      tx_en   = 1'b1;
      tx_data = 8'($urandom);
      step();
      tx_en = 1'b0;
      repeat (4 * C + 5) step();
      rst = 1'b1;
      step();
      checks++;
      if (txd !== 1'b1 || tx_busy !== 1'b0 || rx_busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset: got txd=%b tx_busy=%b rx_busy=%b want 1 0 0", txd, tx_busy, rx_busy);
      end
      rst = 1'b0;
      repeat (3) step();
      checks++;
      if (rx_got.size() !== 0) begin
         errors++;
         $display("FAIL midreset_valid: got %0d pulses want 0", rx_got.size());
      end
      d = 8'($urandom);
      tx_frame(d, 1'b0);
      repeat (20) step();
      checks++;
      if (rx_got.size() !== 1 || rx_data !== d) begin
         errors++;
         $display("FAIL midreset_after: got %0d pulses data=%h want 1 pulse data=%h", rx_got.size(), rx_data, d);
      end
   endtask

   task automatic test_low_after_reset();
      bit seen_busy;
      loop_en = 1'b0;
      rxd_drv = 1'b0;
      do_reset(2);
      rx_got.delete();
      seen_busy = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (rx_busy === 1'b1) seen_busy = 1'b1;
         step();
      end
      checks++;
      if (seen_busy || rx_got.size() !== 0) begin
         errors++;
         $display("FAIL low_after_reset: got busy_seen=%0d pulses=%0d want 0 0", seen_busy, rx_got.size());
      end
      rxd_drv = 1'b1;
      repeat (5) step();
   endtask

`ifdef UART_PARITY_EN
   task automatic test_parity();
      loop_en = 1'b1;
      rx_got.delete();
      perr_got.delete();
      tx_frame(8'h07, 1'b0);
      repeat (20) step();
      checks++;
      if (rx_got.size() !== 1 || perr_got.size() !== 1 || rx_got[0] !== 8'h07 || perr_got[0] !== 1'b0) begin
         errors++;
         $display("FAIL parity_loop: got %0d pulses data=%h perr=%b want 1 pulse 07 perr=0",
                  rx_got.size(), rx_data, rx_parity_err);
      end
      loop_en = 1'b0;
      rxd_drv = 1'b1;
      repeat (4) step();
      rx_got.delete();
      perr_got.delete();
      rx_drive(8'h07, 1'b1, 1'b1);
      checks++;
      if (rx_got.size() !== 1 || perr_got.size() !== 1 || rx_got[0] !== 8'h07 || perr_got[0] !== 1'b1) begin
         errors++;
         $display("FAIL parity_flip: got %0d pulses data=%h perr=%b want 1 pulse 07 perr=1",
                  rx_got.size(), rx_data, rx_parity_err);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_tx_pattern();
      test_back_to_back();
      test_rx_frames();
      test_glitch();
      test_reset_mid_tx();
      test_low_after_reset();
`ifdef UART_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
